// File: rtl/prio_grant_pkg.sv
// Shared types and width helpers for the fixed-priority grant responder.
package prio_grant_pkg;

  // Responder FSM: IDLE waits for requests, BUSY holds a captured word.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned STARVE_DEFAULT = 3;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of an age counter able to hold values 0..starve.
  function automatic int unsigned age_width(input int unsigned starve);
    return (starve < 1) ? 1 : $clog2(starve + 1);
  endfunction

  // Age counter type for the default starvation threshold.
  typedef logic [age_width(STARVE_DEFAULT)-1:0] age_t;

endpackage

// File: rtl/prio_grant_responder_pick.sv
// Combinational lowest-index picker: reports whether any mask bit is set
// and the index of the lowest set bit (index 0 has highest priority).
module prio_pick
  import prio_grant_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  // w_chain[i] is the winner among bits i..N-1; building it from the top
  // down gives the same result as a nested ?: chain starting at bit 0.
  logic [IW-1:0] w_chain [N+1];

  assign w_chain[N] = '0;

  for (genvar i = N - 1; i >= 0; i--) begin : g_chain
    assign w_chain[i] = i_mask[i] ? IW'(i) : w_chain[i+1];
  end

  assign o_any = |i_mask;
  assign o_idx = w_chain[0];

endmodule

// File: rtl/prio_grant_responder.sv
// Fixed-priority responder: captures one requester's word, pulses its grant
// for one cycle and presents the word on a valid/ready output port.
// Handshake: a word transfers at a rising edge where out_valid and out_ready
// are both 1; out_valid, out_data and out_id stay stable until then, and
// out_ready has no effect while out_valid is 0.
module prio_grant_responder
  import prio_grant_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int STARVE = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             req,
  input  logic [N*DW-1:0]          req_data,
  output logic [N-1:0]             gnt,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [id_width(N)-1:0]   out_id,
  input  logic                     out_ready,
  output state_t                   o_dbg_state
);

  localparam int IW = id_width(N);
  localparam int AW = age_width(STARVE);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE);

  state_t          r_state;
  state_t          w_next_state;
  logic            w_capture;
  logic            w_accept;
  logic [N-1:0]    r_gnt;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic [IW-1:0]   r_id;
  logic [AW-1:0]   r_age [N];
  logic [N-1:0]    w_starved;
  logic            w_any_s;
  logic            w_any_r;
  logic [IW-1:0]   w_idx_s;
  logic [IW-1:0]   w_idx_r;
  logic [IW-1:0]   w_win;
  logic [DW-1:0]   w_words [N];

  for (genvar i = 0; i < N; i++) begin : g_lanes
    assign w_starved[i] = req[i] & (r_age[i] == AGE_MAX);
    assign w_words[i]   = req_data[i*DW +: DW];
  end

  prio_pick #(.N(N), .IW(IW)) u_pick_starved (
    .i_mask (w_starved),
    .o_any  (w_any_s),
    .o_idx  (w_idx_s)
  );

  prio_pick #(.N(N), .IW(IW)) u_pick_req (
    .i_mask (req),
    .o_any  (w_any_r),
    .o_idx  (w_idx_r)
  );

  // Promoted (starved) requesters take precedence over plain priority.
  assign w_win = w_any_s ? w_idx_s : w_idx_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode: capture in IDLE, release on accepted handshake in BUSY.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_r) begin
          w_capture    = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (r_valid && out_ready) begin
          w_accept     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output registers: grant pulses only on the capture edge, word held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_gnt <= '0;
      if (w_capture) begin
        r_gnt   <= N'(1) << w_win;
        r_valid <= 1'b1;
        r_data  <= w_words[w_win];
        r_id    <= w_win;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Age counters advance only at capture edges; losers that keep requesting saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < N; i++) begin
        if (w_win == IW'(i))        r_age[i] <= '0;
        else if (req[i])            r_age[i] <= (r_age[i] == AGE_MAX) ? AGE_MAX : r_age[i] + 1'b1;
        else                        r_age[i] <= '0;
      end
    end
  end

  assign gnt         = r_gnt;
  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_id      = r_id;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prio_grant_responder.sv
// Bench for prio_grant_responder: directed scenarios plus random requesters,
// checked by a transaction-level model feeding an expected-word queue.
module tb_prio_grant_responder;
  import prio_grant_pkg::*;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int STARVE = 3;
  localparam int IW     = 2;
  localparam int W      = N + IW + DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            out_ready = 1'b0;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  state_t          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  int           got_ids[$];
  int           m_age[N];
  bit           m_valid;
  logic [W-1:0] cur;
  bit           prev_valid;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  prio_grant_responder #(.N(N), .DW(DW), .STARVE(STARVE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_ready   (out_ready),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: one transaction per capture, winner from ages and request set.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (req != '0) begin
      int w;
      w = -1;
      for (int i = 0; i < N; i++) if (w < 0 && req[i] && m_age[i] >= STARVE) w = i;
      if (w < 0) for (int i = 0; i < N; i++) if (w < 0 && req[i]) w = i;
      exp_q.push_back({N'(1 << w), IW'(w), req_data[w*DW +: DW]});
      for (int i = 0; i < N; i++) begin
        if (i == w)      m_age[i] = 0;
        else if (req[i]) m_age[i] = (m_age[i] + 1 > STARVE) ? STARVE : m_age[i] + 1;
        else             m_age[i] = 0;
      end
      m_valid = 1'b1;
    end
  end

  // Monitor: pops an expected word when a new word appears, checks it is held stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL capture: unexpected word id=%0d data=%0h", out_id, out_data);
          cur = {gnt, out_id, out_data};
        end else begin
          cur = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(cur[W-1 -: N]));
          check("out_id", 32'(out_id), 32'(cur[DW +: IW]));
          check("out_data", 32'(out_data), 32'(cur[DW-1:0]));
        end
        got_ids.push_back(int'(out_id));
      end else if (out_valid) begin
        check("hold_data", 32'(out_data), 32'(cur[DW-1:0]));
        check("hold_id", 32'(out_id), 32'(cur[DW +: IW]));
        check("gnt_pulse", 32'(gnt), 32'(0));
      end else begin
        check("gnt_idle", 32'(gnt), 32'(0));
      end
      prev_valid = out_valid;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_gnt();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_gnt: no grant within 20 cycles");
    end
  endtask

  task automatic check_ids(input string name, input int exp_ids[$]);
    check({name, "_count"}, 32'(got_ids.size()), 32'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++)
      check(name, 32'(got_ids[i]), 32'(exp_ids[i]));
  endtask

  task automatic rand_step();
    for (int i = 0; i < N; i++) begin
      if (req[i] && gnt[i]) begin
        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        else req_data[i*DW +: DW] = 8'($urandom);
      end else if (!req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        req_data[i*DW +: DW] = 8'($urandom);
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Stimulus sequence.
  initial begin
    // Reset state while rst_n is held low.
    #12;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_id", 32'(out_id), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Priority order: requester 1 beats 2, then 2 is served.
    @(negedge clk);
    req_data[1*DW +: DW] = 8'h3C;
    req_data[2*DW +: DW] = 8'hA5;
    req = 4'b0110;
    out_ready = 1'b1;
    wait_gnt();
    check("t2_id1", 32'(out_id), 32'd1);
    check("t2_data1", 32'(out_data), 32'h3C);
    check("t2_gnt1", 32'(gnt), 32'b0010);
    req = 4'b0100;
    wait_gnt();
    check("t2_id2", 32'(out_id), 32'd2);
    check("t2_data2", 32'(out_data), 32'hA5);
    check("t2_gnt2", 32'(gnt), 32'b0100);
    req = '0;
    repeat (2) @(negedge clk);

    // Backpressure: word held for 5 cycles, released when out_ready rises.
    do_reset();
    @(negedge clk);
    req_data[0 +: DW] = 8'h5A;
    req = 4'b0001;
    out_ready = 1'b0;
    wait_gnt();
    req = '0;
    repeat (5) @(negedge clk);
    check("t3_valid_held", 32'(out_valid), 32'd1);
    check("t3_data_held", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_drop", 32'(out_valid), 32'd0);
    check("t3_state", 32'(dbg_state), 32'(IDLE));

    // Reset while a word is pending.
    do_reset();
    @(negedge clk);
    req_data[1*DW +: DW] = 8'h77;
    req = 4'b0010;
    out_ready = 1'b0;
    wait_gnt();
    req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", 32'(out_valid), 32'd0);
    check("t1_gnt", 32'(gnt), 32'd0);
    check("t1_data", 32'(out_data), 32'd0);
    check("t1_id", 32'(out_id), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t1_state", 32'(dbg_state), 32'(IDLE));

    // Starvation: requesters 0 and 3 held continuously.
    do_reset();
    got_ids.delete();
    @(negedge clk);
    req_data[0 +: DW]    = 8'h11;
    req_data[3*DW +: DW] = 8'h33;
    req = 4'b1001;
    out_ready = 1'b1;
    repeat (16) @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check_ids("t4_seq", '{0, 0, 0, 3, 0, 0, 0, 3});

    // Two requesters saturate together: lower index promoted first.
    do_reset();
    got_ids.delete();
    @(negedge clk);
    req_data[2*DW +: DW] = 8'h22;
    req = 4'b1101;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    check_ids("t5_seq", '{0, 0, 0, 2, 3});

    // No requests while out_ready toggles: nothing is granted.
    do_reset();
    got_ids.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = ~out_ready;
    end
    check("t6_no_words", 32'(got_ids.size()), 32'd0);

    // Random requesters and backpressure.
    do_reset();
    repeat (500) begin
      @(negedge clk);
      rand_step();
    end
    @(negedge clk);
    req = '0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_q", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
